// File: rtl/lfsr_burst_ctrl_pkg.sv
// Shared definitions for the LFSR burst controller: state encoding and LFSR defaults.
package lfsr_burst_ctrl_pkg;

    localparam int NB_LFSR = 8;
    localparam logic [NB_LFSR-1:0] DEFAULT_SEED = 8'h01;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    function automatic logic state_is_busy(input state_e st);
        return (st != ST_IDLE);
    endfunction

endpackage

// File: rtl/lfsr_burst_ctrl.sv
// Burst sequencer driving an external Galois LFSR: seed load, N handshaked bytes, done pulse.
// Optional all-zero lock-up recovery is compiled in with `define LFSR_LOCKUP_RECOVERY_EN.
module lfsr_burst_ctrl
    import lfsr_burst_ctrl_pkg::*;
#(
    parameter int                 NB_LFSR      = lfsr_burst_ctrl_pkg::NB_LFSR,
    parameter int                 NB_LEN       = 16,
    parameter logic [NB_LFSR-1:0] DEFAULT_SEED = lfsr_burst_ctrl_pkg::DEFAULT_SEED
) (
    input  logic               clk,
    input  logic               i_rst,
    input  logic               i_start,
    input  logic               i_abort,
    input  logic [NB_LFSR-1:0] i_seed,
    input  logic [NB_LEN-1:0]  i_burst_len,
    input  logic [NB_LFSR-1:0] i_lfsr,
    output logic               o_lfsr_valid,
    output logic               o_lfsr_soft_reset,
    output logic [NB_LFSR-1:0] o_lfsr_seed,
    output logic [NB_LFSR-1:0] o_data,
    output logic               o_data_valid,
    input  logic               i_data_ready,
    output logic               o_busy,
    output logic               o_done
`ifdef LFSR_LOCKUP_RECOVERY_EN
    ,
    output logic               o_lockup
`endif
);

    localparam logic [NB_LEN-1:0] LEN_ONE = {{(NB_LEN-1){1'b0}}, 1'b1};

    state_e             state_q, state_d;
    logic [NB_LEN-1:0]  cnt_q, cnt_d;
    logic [NB_LEN-1:0]  len_q, len_d;
    logic [NB_LFSR-1:0] seed_q, seed_d;
    logic               busy_q, busy_d;
    logic               run_q, run_d;
    logic               load_q, load_d;
    logic               done_q, done_d;
    logic               lockup_now_s;
    logic               xfer_s;

`ifdef LFSR_LOCKUP_RECOVERY_EN
    logic               lockup_q, lockup_d;

    // An all-zero LFSR state can never leave zero, so it is treated as a fault in RUN.
    assign lockup_now_s = run_q && (i_lfsr == {NB_LFSR{1'b0}});
    assign o_lockup     = lockup_q;
`else
    assign lockup_now_s = 1'b0;
`endif

    assign xfer_s            = run_q && !lockup_now_s && i_data_ready;
    assign o_data            = i_lfsr;
    assign o_data_valid      = run_q && !lockup_now_s;
    assign o_lfsr_valid      = xfer_s;
    assign o_lfsr_soft_reset = load_q || lockup_now_s;
    assign o_lfsr_seed       = lockup_now_s ? DEFAULT_SEED : seed_q;
    assign o_busy            = busy_q;
    assign o_done            = done_q;

    // Next-state, counter and capture logic; the output flags are decoded from the next state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        seed_d  = seed_q;
        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    seed_d  = (i_seed == {NB_LFSR{1'b0}}) ? DEFAULT_SEED : i_seed;
                    len_d   = i_burst_len;
                    cnt_d   = {NB_LEN{1'b0}};
                    state_d = ST_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (i_abort) begin
                    state_d = ST_IDLE;
                end else if (len_q == {NB_LEN{1'b0}}) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (xfer_s) begin
                    cnt_d = cnt_q + LEN_ONE;
                end else begin
                    cnt_d = cnt_q;
                end
                if (i_abort) begin
                    state_d = ST_IDLE;
                end else if (xfer_s && (cnt_q == (len_q - LEN_ONE))) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = state_is_busy(state_d);
        run_d  = (state_d == ST_RUN);
        load_d = (state_d == ST_LOAD);
        done_d = (state_d == ST_DONE);
    end

`ifdef LFSR_LOCKUP_RECOVERY_EN
    // Sticky lock-up flag, cleared only when a new burst is accepted.
    always_comb begin
        lockup_d = lockup_q;
        if ((state_q == ST_IDLE) && i_start) begin
            lockup_d = 1'b0;
        end else if (lockup_now_s) begin
            lockup_d = 1'b1;
        end else begin
            lockup_d = lockup_q;
        end
    end

    // Lock-up flag register.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            lockup_q <= 1'b0;
        end else begin
            lockup_q <= lockup_d;
        end
    end
`endif

    // FSM state, burst bookkeeping and registered output flags.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= {NB_LEN{1'b0}};
            len_q   <= {NB_LEN{1'b0}};
            seed_q  <= DEFAULT_SEED;
            busy_q  <= 1'b0;
            run_q   <= 1'b0;
            load_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            seed_q  <= seed_d;
            busy_q  <= busy_d;
            run_q   <= run_d;
            load_q  <= load_d;
            done_q  <= done_d;
        end
    end

endmodule
